// File: rtl/timer_bank_pkg.sv
// -----------------------------------------------------------------------------
// timer_bank_pkg
// Shared definitions for the timer bank: register word offsets inside a
// channel's 8-byte window, CTRL bit positions, address field positions and a
// helper that packs the CTRL read value.
// -----------------------------------------------------------------------------
package timer_bank_pkg;

    // Word offset inside one channel window (addr[2:1]).
    typedef enum logic [1:0] {
        WORD_COUNT  = 2'd0,
        WORD_RELOAD = 2'd1,
        WORD_CTRL   = 2'd2,
        WORD_RSVD   = 2'd3
    } word_e;

    // CTRL register bit positions.
    localparam int CTRL_IF_BIT   = 0;
    localparam int CTRL_IE_BIT   = 1;
    localparam int CTRL_MODE_BIT = 2;

    // Address field positions.
    localparam int ADDR_CH_MSB   = 6;
    localparam int ADDR_CH_LSB   = 3;
    localparam int ADDR_WORD_MSB = 2;
    localparam int ADDR_WORD_LSB = 1;

    localparam int REG_WIDTH = 16;

    // CTRL read value; bits above MODE read as zero.
    function automatic logic [REG_WIDTH-1:0] ctrl_word(input logic flag,
                                                       input logic ie,
                                                       input logic mode);
        logic [REG_WIDTH-1:0] w;
        w                = '0;
        w[CTRL_IF_BIT]   = flag;
        w[CTRL_IE_BIT]   = ie;
        w[CTRL_MODE_BIT] = mode;
        return w;
    endfunction

endpackage

// File: rtl/timer_bank_ch.sv
// -----------------------------------------------------------------------------
// timer_bank_ch
// One countdown channel: COUNT, RELOAD, IF, IE, MODE and the expiry logic.
// Configuration macro: TIMER_BANK_PERIODIC_EN enables RELOAD/MODE storage and
// auto-reload at expiry; without it the channel is one-shot and RELOAD/MODE
// read as zero.
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   tick      in   one-cycle countdown strobe from the shared prescaler
//   wr_count  in   COUNT write strobe for this channel
//   wr_reload in   RELOAD write strobe for this channel
//   wr_ctrl   in   CTRL write strobe for this channel
//   wr_data   in   16-bit write data
//   count     out  current COUNT
//   reload    out  current RELOAD (zero when periodic mode is not built)
//   flag      out  IF, expiry flag
//   ie        out  IE, interrupt enable
//   mode      out  MODE, 1 = periodic (zero when periodic mode is not built)
// -----------------------------------------------------------------------------
module timer_bank_ch
    import timer_bank_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 wr_count,
    input  logic                 wr_reload,
    input  logic                 wr_ctrl,
    input  logic [15:0]          wr_data,
    output logic [CNT_WIDTH-1:0] count,
    output logic [CNT_WIDTH-1:0] reload,
    output logic                 flag,
    output logic                 ie,
    output logic                 mode
);

    logic expiry;
    logic restart;
    logic unused_ch;

    // A COUNT write in the tick cycle owns the channel, so it suppresses expiry.
    assign expiry  = tick && !wr_count && (count == CNT_WIDTH'(1));
    assign restart = mode && (reload != '0);

    // Upper data bits (narrow counters) and the RELOAD strobe (one-shot build)
    // may have no consumer.
    assign unused_ch = ^{wr_data, wr_reload};

`ifdef TIMER_BANK_PERIODIC_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            reload <= '0;
            mode   <= 1'b0;
        end else begin
            if (wr_reload) begin
                reload <= wr_data[CNT_WIDTH-1:0];
            end
            if (wr_ctrl) begin
                mode <= wr_data[CTRL_MODE_BIT];
            end
        end
    end
`else
    assign reload = '0;
    assign mode   = 1'b0;
`endif

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (wr_count) begin
            count <= wr_data[CNT_WIDTH-1:0];
        end else if (expiry) begin
            count <= restart ? reload : '0;
        end else if (tick && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    // Expiry outranks a same-cycle write-1-to-clear; a COUNT write clears IF.
    always_ff @(posedge clk) begin
        if (rst) begin
            flag <= 1'b0;
        end else if (wr_count) begin
            flag <= 1'b0;
        end else if (expiry) begin
            flag <= 1'b1;
        end else if (wr_ctrl && wr_data[CTRL_IF_BIT]) begin
            flag <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ie <= 1'b0;
        end else if (wr_ctrl) begin
            ie <= wr_data[CTRL_IE_BIT];
        end
    end

endmodule

// File: rtl/timer_bank.sv
// -----------------------------------------------------------------------------
// timer_bank
// Bank of NUM_CH countdown timers sharing one prescaler that produces a tick
// at TICK_HZ from CLOCK_HZ. Registers are reached through a 7-bit byte offset:
// addr[6:3] channel, addr[2:1] word (COUNT, RELOAD, CTRL, reserved).
// Configuration macro: TIMER_BANK_PERIODIC_EN (see timer_bank_ch).
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   addr     in   byte offset into the register region
//   wr       in   16-bit register write strobe
//   wr_data  in   write data
//   rd_data  out  registered read data for the previous cycle's addr
//   irq      out  OR over channels of IF & IE
//   irq_ch   out  lowest channel with IF & IE, 0 when irq is low
//   timeout  out  per-channel IF
// -----------------------------------------------------------------------------
module timer_bank
    import timer_bank_pkg::*;
#(
    parameter int CLOCK_HZ  = 27_000_000,
    parameter int TICK_HZ   = 1000,
    parameter int NUM_CH    = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [6:0]        addr,
    input  logic              wr,
    input  logic [15:0]       wr_data,
    output logic [15:0]       rd_data,
    output logic              irq,
    output logic [3:0]        irq_ch,
    output logic [NUM_CH-1:0] timeout
);

    localparam int PERIOD = CLOCK_HZ / TICK_HZ;
    localparam int PRE_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PERIOD - 1);

    // ---------------------------------------------------------------- prescaler
    logic [PRE_W-1:0] pre;
    logic             tick;

    assign tick = (pre == PRE_LAST);

    always_ff @(posedge clk) begin
        if (rst || tick) begin
            pre <= '0;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    // ------------------------------------------------------------------ decode
    logic [3:0] sel_ch;
    word_e      sel_word;
    logic       unused_addr_lsb;

    assign sel_ch          = addr[ADDR_CH_MSB:ADDR_CH_LSB];
    assign sel_word        = word_e'(addr[ADDR_WORD_MSB:ADDR_WORD_LSB]);
    assign unused_addr_lsb = addr[0];

    // ---------------------------------------------------------------- channels
    logic [NUM_CH-1:0]    wr_count;
    logic [NUM_CH-1:0]    wr_reload;
    logic [NUM_CH-1:0]    wr_ctrl;
    logic [NUM_CH-1:0]    flag;
    logic [NUM_CH-1:0]    ie;
    logic [NUM_CH-1:0]    mode;
    logic [CNT_WIDTH-1:0] count  [NUM_CH];
    logic [CNT_WIDTH-1:0] reload [NUM_CH];

    // Channel numbers at or above NUM_CH match no instance, so such writes
    // fall away here without extra range checks.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic hit;
        assign hit          = wr && (sel_ch == 4'(i));
        assign wr_count[i]  = hit && (sel_word == WORD_COUNT);
        assign wr_reload[i] = hit && (sel_word == WORD_RELOAD);
        assign wr_ctrl[i]   = hit && (sel_word == WORD_CTRL);

        timer_bank_ch #(
            .CNT_WIDTH(CNT_WIDTH)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .tick     (tick),
            .wr_count (wr_count[i]),
            .wr_reload(wr_reload[i]),
            .wr_ctrl  (wr_ctrl[i]),
            .wr_data  (wr_data),
            .count    (count[i]),
            .reload   (reload[i]),
            .flag     (flag[i]),
            .ie       (ie[i]),
            .mode     (mode[i])
        );
    end

    // ---------------------------------------------------------------- read mux
    logic [15:0] rd_next;

    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        rd_next = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel_ch == 4'(i)) begin
                case (sel_word)
                    WORD_COUNT:  rd_next = 16'(count[i]);
                    WORD_RELOAD: rd_next = 16'(reload[i]);
                    WORD_CTRL:   rd_next = ctrl_word(flag[i], ie[i], mode[i]);
                    default:     rd_next = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_next;
        end
    end

    // ------------------------------------------------------ interrupt outputs
    logic [NUM_CH-1:0] pending;

    assign pending = flag & ie;
    assign irq     = |pending;
    assign timeout = flag;

    // Scan from the top down so the lowest pending channel is written last.
    always_comb begin
        irq_ch = 4'd0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pending[i]) begin
                irq_ch = 4'(i);
            end
        end
    end

endmodule

// File: tb/tb_timer_bank.sv
// -----------------------------------------------------------------------------
// tb_timer_bank
// Self-checking bench for timer_bank with CLOCK_HZ=8, TICK_HZ=1 (tick every
// 8 clocks), NUM_CH=4, CNT_WIDTH=16. Directed scenarios plus a randomized run
// against a behavioural model of the register map and countdown rules.
// -----------------------------------------------------------------------------
module tb_timer_bank;

    localparam int CLOCK_HZ  = 8;
    localparam int TICK_HZ   = 1;
    localparam int NUM_CH    = 4;
    localparam int CNT_WIDTH = 16;
    localparam int PERIOD    = CLOCK_HZ / TICK_HZ;
`ifdef TIMER_BANK_PERIODIC_EN
    localparam bit PERIODIC = 1'b1;
`else
    localparam bit PERIODIC = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [6:0]        addr = '0;
    logic              wr = 1'b0;
    logic [15:0]       wr_data = '0;
    logic [15:0]       rd_data;
    logic              irq;
    logic [3:0]        irq_ch;
    logic [NUM_CH-1:0] timeout;

    timer_bank #(
        .CLOCK_HZ (CLOCK_HZ),
        .TICK_HZ  (TICK_HZ),
        .NUM_CH   (NUM_CH),
        .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .addr   (addr),
        .wr     (wr),
        .wr_data(wr_data),
        .rd_data(rd_data),
        .irq    (irq),
        .irq_ch (irq_ch),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // ------------------------------------------------------ behavioural model
    int          m_count  [NUM_CH];
    int          m_reload [NUM_CH];
    bit          m_if     [NUM_CH];
    bit          m_ie     [NUM_CH];
    bit          m_mode   [NUM_CH];
    int          m_cycles;          // clocks since reset, modulo PERIOD
    bit          m_tick;            // the last edge was a tick edge
    logic [15:0] m_rd;

    function automatic logic [15:0] model_read(input logic [6:0] a);
        int c;
        int w;
        c = int'(a[6:3]);
        w = int'(a[2:1]);
        if (c >= NUM_CH) return 16'h0000;
        case (w)
            0:       return 16'(m_count[c]);
            1:       return 16'(m_reload[c]);
            2:       return {13'd0, m_mode[c], m_ie[c], m_if[c]};
            default: return 16'h0000;
        endcase
    endfunction

    function automatic void model_outs(output logic e_irq, output logic [3:0] e_ch,
                                       output logic [NUM_CH-1:0] e_to);
        e_irq = 1'b0;
        e_ch  = 4'd0;
        e_to  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            e_to[c] = m_if[c];
            if (m_if[c] && m_ie[c] && !e_irq) begin
                e_irq = 1'b1;
                e_ch  = 4'(c);
            end
        end
    endfunction

    function automatic void model_edge(input bit r, input bit w, input logic [6:0] a,
                                       input logic [15:0] d);
        m_rd = r ? 16'h0000 : model_read(a);
        if (r) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_count[c] = 0; m_reload[c] = 0;
                m_if[c] = 0; m_ie[c] = 0; m_mode[c] = 0;
            end
            m_cycles = 0;
            m_tick   = 0;
            return;
        end
        // The tick lands on the PERIOD-th clock after the prescaler restarts.
        m_tick   = (m_cycles == PERIOD - 1);
        m_cycles = (m_cycles + 1) % PERIOD;
        for (int c = 0; c < NUM_CH; c++) begin
            bit hit;
            bit expired;
            int wd;
            hit     = w && (int'(a[6:3]) == c);
            wd      = int'(a[2:1]);
            expired = m_tick && (m_count[c] == 1);
            if (hit && wd == 0) begin
                m_count[c] = int'(d);
                m_if[c]    = 0;
            end else begin
                if (expired) begin
                    m_if[c]    = 1;
                    m_count[c] = (PERIODIC && m_mode[c] && m_reload[c] != 0) ? m_reload[c] : 0;
                end else if (m_tick && m_count[c] != 0) begin
                    m_count[c] = m_count[c] - 1;
                end
                if (hit && wd == 2 && d[0] && !expired) m_if[c] = 0;
            end
            if (hit && wd == 2) begin
                m_ie[c] = d[1];
                if (PERIODIC) m_mode[c] = d[2];
            end
            if (hit && wd == 1 && PERIODIC) m_reload[c] = int'(d);
        end
    endfunction

    // ---------------------------------------------------------------- drivers
    task automatic step(input bit r, input bit w, input logic [6:0] a, input logic [15:0] d);
        rst     = r;
        wr      = w;
        addr    = a;
        wr_data = d;
        @(posedge clk);
        model_edge(r, w, a, d);
        #1;
        rst = 1'b0;
        wr  = 1'b0;
    endtask

    task automatic wait_ticks(input int n, input logic [6:0] a, output bit ok);
        int seen;
        int budget;
        seen   = 0;
        budget = n * PERIOD + 2;
        while (seen < n && budget > 0) begin
            step(1'b0, 1'b0, a, 16'h0000);
            if (m_tick) seen++;
            budget--;
        end
        ok = (seen == n);
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset;
        bit ok;
        step(1'b1, 1'b0, 7'h00, 16'h0000);
        step(1'b0, 1'b1, 7'h04, 16'h0002);
        step(1'b0, 1'b1, 7'h00, 16'h0001);
        step(1'b0, 1'b1, 7'h08, 16'd500);
        wait_ticks(1, 7'h08, ok);
        n_vec++;
        if (!ok || irq !== 1'b1 || timeout !== 4'b0001) begin
            n_bad++;
            $display("FAIL reset_setup: ok=%0d irq=%b timeout=%b, expected irq=1 timeout=0001",
                     ok, irq, timeout);
        end
        step(1'b0, 1'b0, 7'h08, 16'h0000);
        step(1'b1, 1'b1, 7'h00, 16'h1234);
        step(1'b1, 1'b0, 7'h08, 16'h0000);
        n_vec++;
        if (rd_data !== 16'h0 || irq !== 1'b0 || irq_ch !== 4'd0 || timeout !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_outputs: rd=%h irq=%b ch=%0d to=%b, expected all zero",
                     rd_data, irq, irq_ch, timeout);
        end
        for (int c = 0; c < NUM_CH; c++) begin
            for (int w = 0; w < 4; w++) begin
                step(1'b0, 1'b0, 7'((c << 3) | (w << 1)), 16'h0000);
                n_vec++;
                if (rd_data !== 16'h0000) begin
                    n_bad++;
                    $display("FAIL reset_read ch%0d w%0d: rd=%h, expected 0000", c, w, rd_data);
                end
            end
        end
        // The abandoned count must stay stopped across a tick.
        wait_ticks(1, 7'h08, ok);
        step(1'b0, 1'b0, 7'h08, 16'h0000);
        n_vec++;
        if (!ok || rd_data !== 16'h0000 || timeout !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_abandon: ok=%0d rd=%h to=%b, expected 0000 and 0000",
                     ok, rd_data, timeout);
        end
    endtask

    task automatic test_oneshot;
        bit ok;
        step(1'b1, 1'b0, 7'h00, 16'h0000);
        step(1'b0, 1'b1, 7'h04, 16'h0002);
        step(1'b0, 1'b1, 7'h00, 16'h0003);
        wait_ticks(2, 7'h00, ok);
        n_vec++;
        if (!ok || timeout[0] !== 1'b0 || irq !== 1'b0) begin
            n_bad++;
            $display("FAIL oneshot_early: ok=%0d to0=%b irq=%b, expected 0 0", ok, timeout[0], irq);
        end
        wait_ticks(1, 7'h00, ok);
        n_vec++;
        if (!ok || timeout !== 4'b0001 || irq !== 1'b1 || irq_ch !== 4'd0) begin
            n_bad++;
            $display("FAIL oneshot_expire: ok=%0d to=%b irq=%b ch=%0d, expected 0001 1 0",
                     ok, timeout, irq, irq_ch);
        end
        step(1'b0, 1'b1, 7'h04, 16'h0003);
        n_vec++;
        if (irq !== 1'b0 || timeout[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL oneshot_w1c: irq=%b to0=%b, expected 0 0", irq, timeout[0]);
        end
        step(1'b0, 1'b0, 7'h00, 16'h0000);
        n_vec++;
        if (rd_data !== 16'h0000) begin
            n_bad++;
            $display("FAIL oneshot_stopped: count=%h, expected 0000", rd_data);
        end
    endtask

`ifdef TIMER_BANK_PERIODIC_EN
    task automatic test_periodic;
        bit ok;
        step(1'b1, 1'b0, 7'h00, 16'h0000);
        step(1'b0, 1'b1, 7'h0A, 16'h0002);
        step(1'b0, 1'b1, 7'h0C, 16'h0006);
        step(1'b0, 1'b1, 7'h08, 16'h0002);
        wait_ticks(1, 7'h08, ok);
        n_vec++;
        if (!ok || timeout[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL periodic_t1: ok=%0d to1=%b, expected 0", ok, timeout[1]);
        end
        wait_ticks(1, 7'h08, ok);
        n_vec++;
        if (!ok || timeout[1] !== 1'b1 || irq !== 1'b1 || irq_ch !== 4'd1) begin
            n_bad++;
            $display("FAIL periodic_t2: ok=%0d to1=%b irq=%b ch=%0d, expected 1 1 1",
                     ok, timeout[1], irq, irq_ch);
        end
        step(1'b0, 1'b0, 7'h08, 16'h0000);
        n_vec++;
        if (rd_data !== 16'h0002) begin
            n_bad++;
            $display("FAIL periodic_reload: count=%h, expected 0002", rd_data);
        end
        step(1'b0, 1'b1, 7'h0C, 16'h0007);
        n_vec++;
        if (timeout[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL periodic_w1c: to1=%b, expected 0", timeout[1]);
        end
        wait_ticks(1, 7'h08, ok);
        n_vec++;
        if (!ok || timeout[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL periodic_t3: ok=%0d to1=%b, expected 0", ok, timeout[1]);
        end
        wait_ticks(1, 7'h08, ok);
        n_vec++;
        if (!ok || timeout[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL periodic_t4: ok=%0d to1=%b, expected 1", ok, timeout[1]);
        end
    endtask
`endif

    task automatic test_priority;
        bit ok;
        step(1'b1, 1'b0, 7'h00, 16'h0000);
        step(1'b0, 1'b1, 7'h0C, 16'h0002);
        step(1'b0, 1'b1, 7'h1C, 16'h0002);
        step(1'b0, 1'b1, 7'h08, 16'h0001);
        step(1'b0, 1'b1, 7'h10, 16'h0001);
        step(1'b0, 1'b1, 7'h18, 16'h0001);
        wait_ticks(1, 7'h00, ok);
        n_vec++;
        if (!ok || timeout !== 4'b1110 || irq !== 1'b1 || irq_ch !== 4'd1) begin
            n_bad++;
            $display("FAIL prio_both: ok=%0d to=%b irq=%b ch=%0d, expected 1110 1 1",
                     ok, timeout, irq, irq_ch);
        end
        step(1'b0, 1'b1, 7'h0C, 16'h0003);
        n_vec++;
        if (timeout !== 4'b1100 || irq !== 1'b1 || irq_ch !== 4'd3) begin
            n_bad++;
            $display("FAIL prio_ch3: to=%b irq=%b ch=%0d, expected 1100 1 3", timeout, irq, irq_ch);
        end
        step(1'b0, 1'b1, 7'h1C, 16'h0003);
        n_vec++;
        if (timeout !== 4'b0100 || irq !== 1'b0 || irq_ch !== 4'd0) begin
            n_bad++;
            $display("FAIL prio_none: to=%b irq=%b ch=%0d, expected 0100 0 0", timeout, irq, irq_ch);
        end
    endtask

    task automatic test_collision;
        int budget;
        bit tick_hit;
        step(1'b1, 1'b0, 7'h00, 16'h0000);
        step(1'b0, 1'b1, 7'h10, 16'd9);
        budget = 2 * PERIOD;
        while (m_cycles != PERIOD - 1 && budget > 0) begin
            step(1'b0, 1'b0, 7'h10, 16'h0000);
            budget--;
        end
        step(1'b0, 1'b1, 7'h10, 16'h0005);
        tick_hit = m_tick;
        step(1'b0, 1'b0, 7'h10, 16'h0000);
        n_vec++;
        if (!tick_hit || rd_data !== 16'h0005) begin
            n_bad++;
            $display("FAIL coll_count: in_tick=%0d count=%h, expected 1 0005", tick_hit, rd_data);
        end
        step(1'b0, 1'b1, 7'h14, 16'h0002);
        budget = 100;
        while (!(m_count[2] == 1 && m_cycles == PERIOD - 1) && budget > 0) begin
            step(1'b0, 1'b0, 7'h10, 16'h0000);
            budget--;
        end
        step(1'b0, 1'b1, 7'h14, 16'h0003);
        n_vec++;
        if (budget == 0 || !m_tick || timeout[2] !== 1'b1 || irq !== 1'b1 || irq_ch !== 4'd2) begin
            n_bad++;
            $display("FAIL coll_w1c: budget=%0d to2=%b irq=%b ch=%0d, expected 1 1 2",
                     budget, timeout[2], irq, irq_ch);
        end
        step(1'b0, 1'b1, 7'h14, 16'h0003);
        n_vec++;
        if (timeout[2] !== 1'b0 || irq !== 1'b0) begin
            n_bad++;
            $display("FAIL coll_w1c_late: to2=%b irq=%b, expected 0 0", timeout[2], irq);
        end
    endtask

    task automatic test_invalid;
        step(1'b1, 1'b0, 7'h00, 16'h0000);
        step(1'b0, 1'b1, 7'h00, 16'd1000);
        step(1'b0, 1'b1, 7'h0C, 16'h0002);
        step(1'b0, 1'b1, 7'h18, 16'd77);
        step(1'b0, 1'b0, 7'h28, 16'h0000);
        n_vec++;
        if (rd_data !== 16'h0000) begin
            n_bad++;
            $display("FAIL inv_read: rd=%h, expected 0000", rd_data);
        end
        step(1'b0, 1'b1, 7'h28, 16'h1234);
        step(1'b0, 1'b1, 7'h2A, 16'hFFFF);
        step(1'b0, 1'b1, 7'h2C, 16'hFFFF);
        step(1'b0, 1'b1, 7'h06, 16'hFFFF);
        step(1'b0, 1'b0, 7'h06, 16'h0000);
        n_vec++;
        if (rd_data !== 16'h0000) begin
            n_bad++;
            $display("FAIL rsvd_read: rd=%h, expected 0000", rd_data);
        end
        for (int c = 0; c < NUM_CH; c++) begin
            for (int w = 0; w < 3; w++) begin
                step(1'b0, 1'b0, 7'((c << 3) | (w << 1)), 16'h0000);
                n_vec++;
                if (rd_data !== m_rd) begin
                    n_bad++;
                    $display("FAIL inv_state ch%0d w%0d: rd=%h, expected %h", c, w, rd_data, m_rd);
                end
            end
        end
        n_vec++;
        if (timeout !== 4'b0000 || irq !== 1'b0) begin
            n_bad++;
            $display("FAIL inv_flags: to=%b irq=%b, expected 0000 0", timeout, irq);
        end
`ifndef TIMER_BANK_PERIODIC_EN
        step(1'b0, 1'b1, 7'h0A, 16'h0007);
        step(1'b0, 1'b0, 7'h0A, 16'h0000);
        n_vec++;
        if (rd_data !== 16'h0000) begin
            n_bad++;
            $display("FAIL noreload_read: rd=%h, expected 0000", rd_data);
        end
        step(1'b0, 1'b1, 7'h0C, 16'h0006);
        step(1'b0, 1'b0, 7'h0C, 16'h0000);
        n_vec++;
        if (rd_data !== 16'h0002) begin
            n_bad++;
            $display("FAIL nomode_read: rd=%h, expected 0002", rd_data);
        end
`endif
    endtask

    task automatic test_random;
        logic              e_irq;
        logic [3:0]        e_ch;
        logic [NUM_CH-1:0] e_to;
        bit                r;
        bit                w;
        int                c;
        int                wd;
        logic [15:0]       d;
        step(1'b1, 1'b0, 7'h00, 16'h0000);
        for (int n = 0; n < 800; n++) begin
            r  = ($urandom_range(0, 299) == 0);
            w  = ($urandom_range(0, 2) == 0);
            c  = $urandom_range(0, 5);
            wd = $urandom_range(0, 3);
            case (wd)
                0:       d = 16'($urandom_range(0, 5));
                1:       d = 16'($urandom_range(0, 3));
                2:       d = 16'($urandom_range(0, 7));
                default: d = 16'($urandom);
            endcase
            step(r, w, 7'((c << 3) | (wd << 1) | $urandom_range(0, 1)), d);
            model_outs(e_irq, e_ch, e_to);
            n_vec++;
            if (rd_data !== m_rd || irq !== e_irq || irq_ch !== e_ch || timeout !== e_to) begin
                n_bad++;
                $display("FAIL random[%0d]: rd=%h irq=%b ch=%0d to=%b, expected rd=%h irq=%b ch=%0d to=%b",
                         n, rd_data, irq, irq_ch, timeout, m_rd, e_irq, e_ch, e_to);
            end
        end
    endtask

    // ---------------------------------------------------------------- sequence
    initial begin
        #1;
        test_reset();
        test_oneshot();
`ifdef TIMER_BANK_PERIODIC_EN
        test_periodic();
`endif
        test_priority();
        test_collision();
        test_invalid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
